// File: rtl/forward_tracker.sv
// Forwarding select and load-use stall unit for the lc3b ID/EX stage.
// Latency: fwd_sel/hazard_stall are combinational (0 cycles); tracker and counters update on clk.
// Backpressure: advance=0 freezes the tracker; hazard_stall asks upstream to hold ID/EX and inserts a bubble.
module forward_tracker #(
   parameter int NUM_SRC    = 3,
   parameter int NUM_STAGES = 2,
   parameter int LOAD_STAGE = 2,
   parameter int REG_W      = 3,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       advance,
   input  logic                       flush,
   input  logic                       issue_valid,
   input  logic                       issue_regwrite,
   input  logic                       issue_is_load,
   input  logic [REG_W-1:0]           issue_dst,
   input  logic [NUM_SRC*REG_W-1:0]   src_reg,
   input  logic [NUM_SRC-1:0]         src_check,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       hazard_stall,
   output logic [7:0]                 stall_cycles,
   output logic [15:0]                stall_events
);

   // One in-flight producer record; dst/is_load are only meaningful when vld is set.
   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] dst;
      logic             is_load;
   } entry_t;

   // ent_q[1] is EX/MEM, ent_q[2] is MEM/WB, and so on down the pipe.
   entry_t             ent_q [1:NUM_STAGES];
   entry_t             ins_ent;
   logic [SEL_W-1:0]   sel_a [NUM_SRC];
   logic [NUM_SRC-1:0] use_hit;
   logic               stall_prev;

   // Per operand: scan oldest to youngest so the youngest (lowest k) match overwrites older ones.
   always_comb begin
      sel_a   = '{default: '0};
      use_hit = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = NUM_STAGES; k >= 1; k--) begin
            if (src_check[i] && ent_q[k].vld &&
                (ent_q[k].dst == src_reg[i*REG_W +: REG_W])) begin
               sel_a[i]   = SEL_W'(k);
               use_hit[i] = ent_q[k].is_load && (k < LOAD_STAGE);
            end
         end
      end
   end

   // A stall request from any operand holds the whole ID/EX instruction.
   assign hazard_stall = |use_hit;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_sel
         assign fwd_sel[g*SEL_W +: SEL_W] = sel_a[g];
      end
   endgenerate

   // Stalled or flushed issues enter the tracker as bubbles; non-writers are never tracked.
   always_comb begin
      ins_ent         = '0;
      ins_ent.vld     = issue_valid && issue_regwrite && !flush && !hazard_stall;
      ins_ent.dst     = issue_dst;
      ins_ent.is_load = issue_is_load;
   end

   // Tracker shift register: moves only when the pipeline advances, oldest entry drops off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            ent_q[k] <= '0;
         end
      end else if (advance) begin
         ent_q[1] <= ins_ent;
         for (int k = 2; k <= NUM_STAGES; k++) begin
            ent_q[k] <= ent_q[k-1];
         end
      end
   end

   // Stall run length (saturating) and run count (wrapping), counted every clock regardless of advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         stall_events <= '0;
         stall_prev   <= 1'b0;
      end else begin
         if (hazard_stall) begin
            if (stall_cycles != 8'hFF) begin
               stall_cycles <= stall_cycles + 8'd1;
            end
         end else begin
            stall_cycles <= '0;
         end
         if (hazard_stall && !stall_prev) begin
            stall_events <= stall_events + 16'd1;
         end
         stall_prev <= hazard_stall;
      end
   end

endmodule

// File: tb/tb_forward_tracker.sv
// Bench for forward_tracker: default instance plus a deeper NUM_STAGES=4 instance.
// Stimulus pushes expected outputs into a queue; a monitor drains and compares them.
// Runs a few hundred cycles and ends with a single summary line.
module tb_forward_tracker;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   // Default configuration instance
   logic       a_adv, a_fl, a_iv, a_rw, a_ld;
   logic [2:0] a_dst;
   logic [8:0] a_src;
   logic [2:0] a_chk;
   logic [5:0] a_sel;
   logic       a_st;
   logic [7:0] a_cyc;
   logic [15:0] a_evt;

   // Deep configuration instance
   logic       b_adv, b_fl, b_iv, b_rw, b_ld;
   logic [2:0] b_dst;
   logic [5:0] b_src;
   logic [1:0] b_chk;
   logic [5:0] b_sel;
   logic       b_st;
   logic [7:0] b_cyc;
   logic [15:0] b_evt;

   forward_tracker #(.NUM_SRC(3), .NUM_STAGES(2), .LOAD_STAGE(2), .REG_W(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .advance(a_adv), .flush(a_fl),
      .issue_valid(a_iv), .issue_regwrite(a_rw), .issue_is_load(a_ld), .issue_dst(a_dst),
      .src_reg(a_src), .src_check(a_chk), .fwd_sel(a_sel), .hazard_stall(a_st),
      .stall_cycles(a_cyc), .stall_events(a_evt)
   );

   forward_tracker #(.NUM_SRC(2), .NUM_STAGES(4), .LOAD_STAGE(3), .REG_W(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .advance(b_adv), .flush(b_fl),
      .issue_valid(b_iv), .issue_regwrite(b_rw), .issue_is_load(b_ld), .issue_dst(b_dst),
      .src_reg(b_src), .src_check(b_chk), .fwd_sel(b_sel), .hazard_stall(b_st),
      .stall_cycles(b_cyc), .stall_events(b_evt)
   );

   typedef struct {
      string       nm;
      int          d;
      logic [5:0]  sel;
      logic        st;
      logic [7:0]  cyc;
      logic [15:0] evt;
      logic [3:0]  en;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic expect_r(input string nm, input int d, input logic [5:0] sel, input logic st,
                           input logic [7:0] cyc, input logic [15:0] evt, input logic [3:0] en);
      exp_t e;
      e.nm = nm; e.d = d; e.sel = sel; e.st = st; e.cyc = cyc; e.evt = evt; e.en = en;
      sb.push_back(e);
   endtask

   task automatic check_field(input string nm, input string fld, input logic [15:0] got,
                              input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, got, exp);
      end
   endtask

   // Monitor: compare every queued expectation against the current outputs of the named instance.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge reset_n);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.d == 0) begin
               if (e.en[0]) check_field(e.nm, "fwd_sel",      16'(a_sel), 16'(e.sel));
               if (e.en[1]) check_field(e.nm, "hazard_stall", 16'(a_st),  16'(e.st));
               if (e.en[2]) check_field(e.nm, "stall_cycles", 16'(a_cyc), 16'(e.cyc));
               if (e.en[3]) check_field(e.nm, "stall_events", a_evt,      e.evt);
            end else begin
               if (e.en[0]) check_field(e.nm, "fwd_sel",      16'(b_sel), 16'(e.sel));
               if (e.en[1]) check_field(e.nm, "hazard_stall", 16'(b_st),  16'(e.st));
               if (e.en[2]) check_field(e.nm, "stall_cycles", 16'(b_cyc), 16'(e.cyc));
               if (e.en[3]) check_field(e.nm, "stall_events", b_evt,      e.evt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic iv, input logic rw, input logic ld, input logic [2:0] dst,
                          input logic [8:0] src, input logic [2:0] chk, input logic adv,
                          input logic fl);
      a_iv = iv; a_rw = rw; a_ld = ld; a_dst = dst; a_src = src; a_chk = chk;
      a_adv = adv; a_fl = fl;
   endtask

   task automatic drive_b(input logic iv, input logic rw, input logic ld, input logic [2:0] dst,
                          input logic [5:0] src, input logic [1:0] chk, input logic adv,
                          input logic fl);
      b_iv = iv; b_rw = rw; b_ld = ld; b_dst = dst; b_src = src; b_chk = chk;
      b_adv = adv; b_fl = fl;
   endtask

   initial begin
      drive_a(0, 0, 0, 3'd0, 9'd0, 3'd0, 0, 0);
      drive_b(0, 0, 0, 3'd0, 6'd0, 2'd0, 0, 0);
      reset_n = 1'b0;

      // Reset state of both instances
      tick();
      expect_r("reset_a", 0, 6'd0, 0, 8'd0, 16'd0, 4'hF);
      expect_r("reset_b", 1, 6'd0, 0, 8'd0, 16'd0, 4'hF);
      tick();
      reset_n = 1'b1;

      // Priority: two ADD R1 in a row, youngest wins, then older one after a bubble
      tick(); drive_a(1, 1, 0, 3'd1, 9'd0, 3'b000, 1, 0);
      expect_r("prio_empty", 0, 6'd0, 0, 8'd0, 16'd0, 4'h3);
      tick(); drive_a(1, 1, 0, 3'd1, 9'd0, 3'b000, 1, 0);
      tick(); drive_a(1, 0, 0, 3'd0, {3'd7, 3'd6, 3'd1}, 3'b111, 1, 0);
      expect_r("prio_youngest", 0, 6'b000001, 0, 8'd0, 16'd0, 4'h3);
      tick(); drive_a(0, 0, 0, 3'd0, {3'd7, 3'd6, 3'd1}, 3'b111, 1, 0);
      expect_r("prio_older", 0, 6'b000010, 0, 8'd0, 16'd0, 4'h3);

      // Masking and flush
      tick(); drive_a(1, 1, 0, 3'd4, 9'd0, 3'b000, 1, 0);
      tick(); drive_a(1, 1, 0, 3'd5, {3'd0, 3'd0, 3'd4}, 3'b000, 1, 1);
      expect_r("mask_unchecked", 0, 6'd0, 0, 8'd0, 16'd0, 4'h3);
      tick(); drive_a(0, 0, 0, 3'd0, {3'd0, 3'd4, 3'd5}, 3'b011, 1, 0);
      expect_r("flush_bubble", 0, 6'b001000, 0, 8'd0, 16'd0, 4'h3);

      // Load-use: LDR R3 then consumer of R3 on operand 1 (consumer itself writes R6)
      tick(); drive_a(1, 1, 1, 3'd3, 9'd0, 3'b000, 1, 0);
      expect_r("ld_issue", 0, 6'd0, 0, 8'd0, 16'd0, 4'hF);
      tick(); drive_a(1, 1, 0, 3'd6, {3'd0, 3'd3, 3'd0}, 3'b010, 1, 0);
      expect_r("ld_use_stall", 0, 6'b000100, 1, 8'd0, 16'd0, 4'hF);
      tick(); drive_a(1, 1, 0, 3'd6, {3'd0, 3'd3, 3'd6}, 3'b011, 1, 0);
      expect_r("ld_use_fwd", 0, 6'b001000, 0, 8'd1, 16'd1, 4'hF);
      tick(); drive_a(0, 0, 0, 3'd0, {3'd0, 3'd0, 3'd6}, 3'b001, 1, 0);
      expect_r("ld_consumer_ins", 0, 6'b000001, 0, 8'd0, 16'd1, 4'hF);

      // Memory hold during a load-use stall
      tick(); drive_a(1, 1, 1, 3'd2, 9'd0, 3'b000, 1, 0);
      for (int n = 0; n < 4; n++) begin
         tick(); drive_a(1, 0, 0, 3'd0, {3'd2, 3'd0, 3'd0}, 3'b100, 0, 0);
         expect_r($sformatf("hold_%0d", n), 0, 6'b010000, 1, 8'(n), (n == 0) ? 16'd1 : 16'd2, 4'hF);
      end
      tick(); drive_a(1, 0, 0, 3'd0, {3'd2, 3'd0, 3'd0}, 3'b100, 1, 0);
      expect_r("hold_adv", 0, 6'b010000, 1, 8'd4, 16'd2, 4'hF);
      tick(); drive_a(0, 0, 0, 3'd0, {3'd2, 3'd0, 3'd0}, 3'b100, 1, 0);
      expect_r("hold_done", 0, 6'b100000, 0, 8'd5, 16'd2, 4'hF);

      // Reset in the middle of a stall
      tick(); drive_a(1, 1, 1, 3'd2, 9'd0, 3'b000, 1, 0);
      expect_r("hold_clear", 0, 6'd0, 0, 8'd0, 16'd2, 4'hF);
      tick(); drive_a(1, 0, 0, 3'd0, {3'd0, 3'd0, 3'd2}, 3'b001, 0, 0);
      tick();
      tick();
      tick();
      expect_r("pre_reset", 0, 6'b000001, 1, 8'd3, 16'd3, 4'hF);
      @(negedge clk);
      #2;
      expect_r("reset_mid", 0, 6'd0, 0, 8'd0, 16'd0, 4'hF);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      drive_a(0, 0, 0, 3'd0, 9'd0, 3'b000, 1, 0);

      // Deep instance: load R5 then immediate consumer stalls two cycles
      tick(); drive_b(1, 1, 1, 3'd5, 6'd0, 2'b00, 1, 0);
      tick(); drive_b(1, 1, 0, 3'd7, {3'd0, 3'd5}, 2'b01, 1, 0);
      expect_r("p_stall1", 1, 6'b000001, 1, 8'd0, 16'd0, 4'hF);
      tick();
      expect_r("p_stall2", 1, 6'b000010, 1, 8'd1, 16'd1, 4'hF);
      tick();
      expect_r("p_fwd3", 1, 6'b000011, 0, 8'd2, 16'd1, 4'hF);
      tick(); drive_b(0, 0, 0, 3'd0, {3'd7, 3'd5}, 2'b11, 1, 0);
      expect_r("p_deep", 1, 6'b001100, 0, 8'd0, 16'd1, 4'hF);

      // Saturation of stall_cycles under a long memory hold
      tick(); drive_b(1, 1, 1, 3'd1, 6'd0, 2'b00, 1, 0);
      tick(); drive_b(1, 0, 0, 3'd0, {3'd0, 3'd1}, 2'b01, 0, 0);
      expect_r("sat_start", 1, 6'b000001, 1, 8'd0, 16'd1, 4'hF);
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (n == 254) expect_r("sat_254", 1, 6'b000001, 1, 8'd254, 16'd2, 4'hF);
         if (n == 255) expect_r("sat_255", 1, 6'b000001, 1, 8'd255, 16'd2, 4'hF);
         if (n == 300) expect_r("sat_300", 1, 6'b000001, 1, 8'd255, 16'd2, 4'hF);
      end

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
